// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide execute unit.
// Helpers work on a wide container; callers zero-extend in and truncate out.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } md_state_e;

    localparam int MD_MAXW = 128;

    function automatic logic [MD_MAXW-1:0] md_neg(input logic [MD_MAXW-1:0] v);
        return ~v + MD_MAXW'(1);
    endfunction

    // Magnitude of a twos-complement value whose sign is given by neg.
    function automatic logic [MD_MAXW-1:0] md_abs(input logic [MD_MAXW-1:0] v, input logic neg);
        return neg ? md_neg(v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Decode/ctrl <-> multiply/divide unit handshake; signal names follow the unit's port list.
interface ex_muldiv_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [XLEN-1:0]   op1_i;
    logic [XLEN-1:0]   op2_i;
    logic [REG_AW-1:0] reg_w_addr_i;
    logic              flush_i;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [XLEN-1:0]   result_o;
    logic              reg_w_ena_o;
    logic [REG_AW-1:0] reg_w_addr_o;

    modport master (
        output start_i, op_i, op1_i, op2_i, reg_w_addr_i, flush_i,
        input  stall_o, busy_o, done_o, result_o, reg_w_ena_o, reg_w_addr_o
    );

    modport slave (
        input  start_i, op_i, op1_i, op2_i, reg_w_addr_i, flush_i,
        output stall_o, busy_o, done_o, result_o, reg_w_ena_o, reg_w_addr_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// One STEP-bit iteration of shift-add multiply or restoring divide on a shared adder.
// hi/lo hold {partial product, multiplier} or {partial remainder, dividend/quotient}.
module ex_muldiv_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi, lo;
    logic [XLEN:0]   a, addend, sum;
    logic            cin;

    always_comb begin
        hi     = hi_i;
        lo     = lo_i;
        a      = '0;
        addend = '0;
        sum    = '0;
        cin    = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            // Divide subtracts via inverted addend + carry-in; multiply adds b when the multiplier bit is set.
            if (is_div) begin
                a      = {hi, lo[XLEN-1]};
                addend = ~{1'b0, b_i};
                cin    = 1'b1;
            end else begin
                a      = {1'b0, hi};
                addend = lo[0] ? {1'b0, b_i} : '0;
                cin    = 1'b0;
            end
            sum = a + addend + {{XLEN{1'b0}}, cin};
            if (is_div) begin
                hi = sum[XLEN] ? a[XLEN-1:0] : sum[XLEN-1:0];
                lo = {lo[XLEN-2:0], ~sum[XLEN]};
            end else begin
                hi = sum[XLEN:1];
                lo = {sum[0], lo[XLEN-1:1]};
            end
        end
        hi_o = hi;
        lo_o = lo;
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M MUL/MULH*/DIV*/REM* unit: stalls ctrl while iterating, then one write-back pulse.
// Optional EX_MULDIV_REUSE_EN keeps the last divide's quotient/remainder for a matching DIV/REM pair.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STEP   = 1,
    parameter int REG_AW = 5
) (
    input logic        clk,
    input logic        arst_n,
    ex_muldiv_if.slave bus
);

    localparam int N     = XLEN / STEP;
    localparam int CW    = $clog2(N + 1);
    localparam int PW    = MD_MAXW;
    localparam int PRODW = 2 * XLEN;

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_in;
    logic [XLEN-1:0]   hi_q, lo_q, b_q, result_q, hi_nxt, lo_nxt;
    logic [CW-1:0]     cnt_q;
    logic              nq_q, nr_q;
    logic [REG_AW-1:0] waddr_q;

    logic              s1, s2, n1, n2, is_div, div_zero, div_ovf, special, take, hit;
    logic [XLEN-1:0]   abs1, abs2, spec_res, q_fix, r_fix, fix_res, hit_res;
    logic [PRODW-1:0]  prod;

    assign op_in = md_op_e'(bus.op_i);

    always_comb begin
        s1       = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        s2       = op_in inside {OP_MULH, OP_DIV, OP_REM};
        is_div   = op_in[2];
        n1       = s1 & bus.op1_i[XLEN-1];
        n2       = s2 & bus.op2_i[XLEN-1];
        abs1     = XLEN'(md_abs(PW'(bus.op1_i), n1));
        abs2     = XLEN'(md_abs(PW'(bus.op2_i), n2));
        div_zero = is_div & (bus.op2_i == '0);
        div_ovf  = is_div & s2 & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) spec_res = op_in[1] ? bus.op1_i : '1;
        else          spec_res = op_in[1] ? '0 : bus.op1_i;
        take     = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
    end

    always_comb begin
        prod    = nq_q ? PRODW'(md_neg(PW'({hi_q, lo_q}))) : {hi_q, lo_q};
        q_fix   = XLEN'(md_abs(PW'(lo_q), nq_q));
        r_fix   = XLEN'(md_abs(PW'(hi_q), nr_q));
        if (op_q[2]) fix_res = op_q[1] ? r_fix : q_fix;
        else         fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[PRODW-1:XLEN];
    end

    ex_muldiv_iter #(.XLEN(XLEN), .STEP(STEP)) u_iter (
        .is_div (op_q[2]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .b_i    (b_q),
        .hi_o   (hi_nxt),
        .lo_o   (lo_nxt)
    );

`ifdef EX_MULDIV_REUSE_EN
    logic            cache_v_q, cache_s_q, pend_s_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_qt_q, cache_rm_q, pend_a_q, pend_b_q;

    assign hit     = cache_v_q & is_div & (bus.op1_i == cache_a_q) & (bus.op2_i == cache_b_q)
                   & (s1 == cache_s_q);
    assign hit_res = op_in[1] ? cache_rm_q : cache_qt_q;

    // Operands are held aside until FIXUP so a flushed divide leaves the cache intact.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cache_v_q  <= 1'b0;
            cache_s_q  <= 1'b0;
            pend_s_q   <= 1'b0;
            cache_a_q  <= '0;
            cache_b_q  <= '0;
            cache_qt_q <= '0;
            cache_rm_q <= '0;
            pend_a_q   <= '0;
            pend_b_q   <= '0;
        end else if (take) begin
            pend_a_q <= bus.op1_i;
            pend_b_q <= bus.op2_i;
            pend_s_q <= s1;
            if (special) cache_v_q <= 1'b0;
        end else if (state_q == FIXUP && !bus.flush_i) begin
            cache_v_q <= op_q[2];
            if (op_q[2]) begin
                cache_a_q  <= pend_a_q;
                cache_b_q  <= pend_b_q;
                cache_s_q  <= pend_s_q;
                cache_qt_q <= q_fix;
                cache_rm_q <= r_fix;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = (special || hit) ? DONE : CALC;
            CALC:    if (bus.flush_i) state_d = IDLE;
                     else if (cnt_q == CW'(N - 1)) state_d = FIXUP;
            FIXUP:   state_d = bus.flush_i ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            nq_q     <= 1'b0;
            nr_q     <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
        end else if (take) begin
            op_q    <= op_in;
            hi_q    <= '0;
            lo_q    <= abs1;
            b_q     <= abs2;
            cnt_q   <= '0;
            nq_q    <= n1 ^ n2;
            nr_q    <= n1;
            waddr_q <= bus.reg_w_addr_i;
            if (special)  result_q <= spec_res;
            else if (hit) result_q <= hit_res;
        end else if (state_q == CALC) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CW'(1);
        end else if (state_q == FIXUP && !bus.flush_i) begin
            result_q <= fix_res;
        end
    end

    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.reg_w_ena_o  = (state_q == DONE);
    assign bus.stall_o      = take | (state_q == CALC) | (state_q == FIXUP);
    assign bus.result_o     = result_q;
    assign bus.reg_w_addr_o = waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, flush/reset sequences, random ops vs a reference model.
module tb_ex_muldiv;

    localparam int XLEN   = 32;
    localparam int STEP   = 1;
    localparam int REG_AW = 5;
    localparam int LAT    = XLEN / STEP + 2;
`ifdef EX_MULDIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Model of the divide-reuse cache, tracked from the architectural rules.
    bit          cv = 1'b0;
    logic [31:0] ca, cb;
    bit          cs;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    ex_muldiv #(.XLEN(XLEN), .STEP(STEP), .REG_AW(REG_AW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        bit          ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic bit is_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return REUSE && cv && op[2] && a == ca && b == cb && (!op[0]) == cs;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (is_special(op, a, b) || is_hit(op, a, b)) ? 1 : LAT;
    endfunction

    task automatic commit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hit);
        if (!op[2] || is_special(op, a, b)) cv = 1'b0;
        else if (!hit && REUSE) begin cv = 1'b1; ca = a; cb = b; cs = !op[0]; end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int          lat, lat_exp;
        bit          seen, hit;
        logic [4:0]  addr;
        logic [31:0] res;
        addr    = 5'($urandom_range(1, 31));
        lat_exp = exp_lat(op, a, b);
        hit     = is_hit(op, a, b);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.op1_i = a; bus.op2_i = b; bus.reg_w_addr_i = addr;
        #1 check({name, "/stall_start"}, 32'(bus.stall_o), 32'd1);
        @(posedge clk); #1;
        // Scramble the inputs so any use of unlatched operands shows up.
        bus.start_i = 1'b0; bus.op1_i = $urandom; bus.op2_i = $urandom; bus.op_i = 3'($urandom);
        bus.reg_w_addr_i = 5'($urandom);
        lat = 1; seen = 1'b0;
        while (!seen && lat <= 4 * LAT) begin
            if (bus.done_o) seen = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        check({name, "/done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            res = bus.result_o;
            check({name, "/latency"}, 32'(lat), 32'(lat_exp));
            check({name, "/result"}, res, exp);
            check({name, "/waddr"}, 32'(bus.reg_w_addr_o), 32'(addr));
            check({name, "/wena"}, 32'(bus.reg_w_ena_o), 32'd1);
            check({name, "/stall_done"}, 32'(bus.stall_o), 32'd0);
            @(posedge clk); #1;
            check({name, "/done_pulse"}, 32'(bus.done_o), 32'd0);
            check({name, "/result_hold"}, bus.result_o, res);
        end
        commit(op, a, b, hit);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          r;
        bit          any_done;

        bus.start_i = 1'b0; bus.op_i = '0; bus.op1_i = '0; bus.op2_i = '0;
        bus.reg_w_addr_i = '0; bus.flush_i = 1'b0;

        vecs = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
            '{3'd0, 32'd0,          32'h0001_2345, 32'd0},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
            '{3'd5, 32'h8000_0000,  32'd3,         32'h2AAA_AAAA},
            '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1},
            '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
            '{3'd7, 32'd5,          32'd0,         32'd5},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
            '{3'd5, 32'd7,          32'hFFFF_FFFF, 32'd0}
        };

        #1;
        check("reset/busy", 32'(bus.busy_o), 32'd0);
        check("reset/done", 32'(bus.done_o), 32'd0);
        check("reset/stall", 32'(bus.stall_o), 32'd0);
        check("reset/result", bus.result_o, 32'd0);
        check("reset/waddr", 32'(bus.reg_w_addr_o), 32'd0);
        @(negedge clk); arst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // DIV 100/7, flushed divide, then REM 100/7 (reuse hit only when the cache is built in).
        do_op("mul_pre", 3'd0, 32'd3, 32'd4, 32'd12);
        do_op("div100_7", 3'd4, 32'd100, 32'd7, 32'd14);
        held = bus.result_o;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.op1_i = 32'd9; bus.op2_i = 32'd4;
        @(posedge clk); #1; bus.start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
        check("flush/busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush/busy_after", 32'(bus.busy_o), 32'd0);
        check("flush/stall_after", 32'(bus.stall_o), 32'd0);
        any_done = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge clk); #1;
            if (bus.done_o) any_done = 1'b1;
        end
        check("flush/no_done", 32'(any_done), 32'd0);
        check("flush/result_kept", bus.result_o, held);
        do_op("rem100_7", 3'd6, 32'd100, 32'd7, 32'd2);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd0; bus.op1_i = 32'd3; bus.op2_i = 32'd5; bus.reg_w_addr_i = 5'd9;
        @(posedge clk); #1; bus.start_i = 1'b0;
        for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
        #2 arst_n = 1'b0;
        #1;
        cv = 1'b0;
        check("rst_mid/busy", 32'(bus.busy_o), 32'd0);
        check("rst_mid/done", 32'(bus.done_o), 32'd0);
        check("rst_mid/wena", 32'(bus.reg_w_ena_o), 32'd0);
        check("rst_mid/stall", 32'(bus.stall_o), 32'd0);
        check("rst_mid/result", bus.result_o, 32'd0);
        check("rst_mid/waddr", 32'(bus.reg_w_addr_o), 32'd0);
        @(negedge clk); @(negedge clk); arst_n = 1'b1;
        any_done = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge clk); #1;
            if (bus.done_o) any_done = 1'b1;
        end
        check("rst_mid/no_done", 32'(any_done), 32'd0);
        do_op("after_rst_div", 3'd4, 32'd100, 32'd7, 32'd14);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            r   = $urandom_range(0, 9);
            if (r == 0) rb = 32'd0;
            else if (r == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (r == 2) rb = 32'($urandom_range(1, 15));
            do_op($sformatf("rnd%0d", i), rop, ra, rb, ref_res(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the combinational execute stage. It is started when decode issues an opcode 0110011 instruction with funct7 = 0000001.
- Stalls ctrl while iterating, then delivers one result with a register-write request toward mem/wb.
- Parametrised in data width and bits retired per iteration, which the single-cycle ALU cannot offer.

Parameters:
- XLEN, 32, operand/result width.
- STEP, 1, bits retired per iteration (1, 2 or 4); must divide XLEN.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  3  funct3 of the M instruction.
- op1_i  in  XLEN  rs1 value (forwarded).
- op2_i  in  XLEN  rs2 value (forwarded).
- reg_w_addr_i  in  REG_AW  destination register.
- flush_i  in  1  jump/flush from ctrl; aborts the operation.
- stall_o  out  1  hold request to ctrl.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  XLEN  result; held until the next start.
- reg_w_ena_o  out  1  equals done_o.
- reg_w_addr_o  out  REG_AW  latched destination register.

Behaviour:
- Reset (async, arst_n = 0) state:
  - state IDLE.
  - result_o = 0, reg_w_addr_o = 0.
  - done_o, reg_w_ena_o, busy_o, stall_o all 0.
  - Reset mid-operation discards all work; no done_o follows.
- States:
  - IDLE: on start_i & ~flush_i, latch op, operands and reg_w_addr.
    - Divide by zero or signed overflow -> DONE.
    - Otherwise -> CALC.
  - CALC: run N = XLEN/STEP iterations on absolute values.
    - Multiply: shift-add.
    - Divide: restoring, STEP quotient bits per cycle.
    - Then -> FIXUP.
  - FIXUP: apply sign correction, select hi/lo or quotient/remainder, register result_o. Then -> DONE.
  - DONE: done_o = 1 for exactly one cycle. Then -> IDLE.
- Latency:
  - Normal case: done_o high in cycle N+2 after the start edge (34 for XLEN=32, STEP=1).
  - Special cases: done_o high in cycle 1 after the start edge.
- stall_o:
  - stall_o = (IDLE & start_i & ~flush_i) | CALC | FIXUP.
  - stall_o is 0 in DONE, so the pipeline advances and captures the result that cycle.
- start_i while busy is ignored. Ctrl keeps it asserted only via the stall, and it is not re-sampled until IDLE.
- flush_i in CALC or FIXUP:
  - Return to IDLE next cycle.
  - No done_o.
  - result_o unchanged.
- flush_i in DONE has no effect; the result was committed.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Product is 2*XLEN wide; MUL returns the low half, the MULH variants the high half.
- Signs:
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Divide by zero: quotient = all ones; remainder = op1.
- Signed overflow (op1 = most negative, op2 = -1) for DIV/REM: quotient = op1; remainder = 0.
- Operand value 0 takes the normal path for multiply; no early-out.

Optional Feature:
- Macro: EX_MULDIV_REUSE_EN.
- Defined:
  - After a completed divide, keep operands, signedness, quotient and remainder.
  - A following DIV/REM pair (either order) with identical op1, op2 and signedness goes IDLE -> DONE: done_o at cycle 1, stall_o high only in the start cycle.
  - Any other completed op or reset invalidates the cache.
  - Flush does not invalidate it.
- Undefined: every operation takes the full latency and no cache registers exist.

Decomposition:
- Package muldiv_pkg:
  - funct3 encodings: MUL = 000, MULH = 001, MULHSU = 010, MULHU = 011, DIV = 100, DIVU = 101, REM = 110, REMU = 111.
  - State enum IDLE / CALC / FIXUP / DONE.
  - Helper functions for twos-complement absolute value and negate.
- One sub-module, ex_muldiv_iter: a shared XLEN-wide adder/subtractor datapath.
  - Performs one STEP-bit iteration per cycle for both multiply and divide.
  - Controlled by the FSM in ex_muldiv.

Test Plan:
- MUL op1 = 7, op2 = -3 (XLEN = 32, STEP = 1) -> done_o at cycle 34; result = 0xFFFFFFEB; reg_w_addr_o equals the latched address.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- Sign rules:
  - DIV -7 / 2 -> 0xFFFFFFFD.
  - REM -7 / 2 -> 0xFFFFFFFF.
  - DIVU 0x80000000 / 3 -> 0x2AAAAAAA.
- Special cases, done_o at cycle 1:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 / -1 -> 0.
- Flush and reset:
  - flush_i at cycle 10 of a DIV -> busy_o low next cycle, no done_o, result_o unchanged.
  - arst_n low mid-CALC -> all outputs 0 at once.
  - New start afterwards completes normally.
- With EX_MULDIV_REUSE_EN: DIV 100 / 7 then REM 100 / 7 -> 14 at cycle 34, then 2 at cycle 1. Repeat without the macro -> second result at cycle 34.
